spi_tx_feeder: RTL and testbench

- Upstream stage of the SPI master inside the daisy-chain top.
- Buffers bytes from a producer in a small FIFO.
- Drives the master's newd/din request pair one byte at a time, using the master's cs line to detect transfer start and end.
- Guarantees newd is held until the transfer starts, and enforces a minimum idle gap between frames.

---
 rtl/spi_feeder_pkg.sv | 23 ++
 rtl/sync_fifo_ptr.sv | 46 ++++
 rtl/spi_tx_feeder.sv | 158 +++++++++++++++
 tb/tb_spi_tx_feeder.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_feeder_pkg.sv
// rtl/spi_feeder_pkg.sv - shared state type and sizing helpers for the SPI transmit feeder
package spi_feeder_pkg;

   // Feeder handshake phases; GAP is the enforced cs-high idle time between frames.
   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT_START,
      WAIT_DONE,
      GAP
   } state_t;

   // Index width of a power-of-two FIFO; the pointers carry one extra wrap bit on top.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Width of a counter that must hold values 0..n inclusive.
   function automatic int cnt_w(input int n);
      return (n > 0) ? $clog2(n + 1) : 1;
   endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// rtl/sync_fifo_ptr.sv - circular byte buffer with wrap-bit pointers and occupancy count
module sync_fifo_ptr #(
   parameter int DW    = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [DW-1:0]          wr_data,
   output logic [DW-1:0]          rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   import spi_feeder_pkg::*;

   localparam int AW = ptr_w(DEPTH);

   logic [AW:0]   wptr;
   logic [AW:0]   rptr;
   logic [DW-1:0] mem [DEPTH];

   // Pointers advance on accepted push/pop; the caller has already qualified both.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   // Storage is not reset; only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= wr_data;
   end

   // Head word is visible combinationally so the consumer can latch it on the pop cycle.
   assign rd_data = mem[rptr[AW-1:0]];
   assign count   = wptr - rptr;
   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/spi_tx_feeder.sv
// rtl/spi_tx_feeder.sv - queues bytes and hands them one at a time to the SPI master via newd/din
module spi_tx_feeder #(
   parameter int DW       = 8,
   parameter int DEPTH    = 8,
   parameter int GAP      = 4,
   parameter int START_TO = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [DW-1:0]          wr_data,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   ovf,
   output logic                   err,
   input  logic                   clr_err,
   output logic                   newd,
   output logic [DW-1:0]          din,
   input  logic                   cs,
   output logic                   busy,
   output logic                   sent
);
   import spi_feeder_pkg::*;

   localparam int TW = cnt_w(START_TO);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   state_t        state;
   logic          cs_q;
   logic          fall;
   logic          rise;
   logic          empty;
   logic          launch;
   logic          push;
   logic          drop;
   logic          timeout;
   logic [DW-1:0] head;
   logic [TW-1:0] tmr;
   logic [GW-1:0] gcnt;

   sync_fifo_ptr #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (launch),
      .wr_data (wr_data),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   // cs is in our clock domain, so a single register is enough for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cs_q <= 1'b1;
      else     cs_q <= cs;
   end

   assign fall = cs_q & ~cs;
   assign rise = ~cs_q & cs;

   // A new frame only starts from IDLE with data queued and the bus released.
   assign launch  = (state == IDLE) && !empty && cs;
   // Popping frees a slot in the same cycle, so a write at full is still taken then.
   assign push    = wr_en & (~full | launch);
   assign drop    = wr_en & full & ~launch;
   // tmr counts newd-high cycles including LAUNCH, so newd is held exactly START_TO cycles.
   assign timeout = (state == WAIT_START) && !fall && (tmr >= TW'(START_TO - 1));

   // Sticky status flags; a clear in the same cycle as a set wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
         err <= 1'b0;
      end else if (clr_err) begin
         ovf <= 1'b0;
         err <= 1'b0;
      end else begin
         if (drop)    ovf <= 1'b1;
         if (timeout) err <= 1'b1;
      end
   end

   // Frame sequencer: launch, wait for cs fall (or give up), wait for cs rise, then idle gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         newd  <= 1'b0;
         din   <= '0;
         busy  <= 1'b0;
         sent  <= 1'b0;
         tmr   <= '0;
         gcnt  <= '0;
      end else begin
         sent <= 1'b0;
         case (state)
            IDLE: begin
               if (launch) begin
                  din   <= head;
                  newd  <= 1'b1;
                  busy  <= 1'b1;
                  state <= LAUNCH;
               end
            end
            LAUNCH: begin
               tmr   <= TW'(1);
               state <= WAIT_START;
            end
            WAIT_START: begin
               if (fall) begin
                  newd  <= 1'b0;
                  state <= WAIT_DONE;
               end else if (timeout) begin
                  newd <= 1'b0;
                  gcnt <= '0;
                  if (GAP == 0) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     state <= spi_feeder_pkg::GAP;
                  end
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (rise) begin
                  sent <= 1'b1;
                  gcnt <= '0;
                  if (GAP == 0) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     state <= spi_feeder_pkg::GAP;
                  end
               end
            end
            spi_feeder_pkg::GAP: begin
               if (gcnt == GW'(GAP - 1)) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  gcnt <= gcnt + 1'b1;
               end
            end
            default: begin
               newd  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_tx_feeder.sv
// tb/tb_spi_tx_feeder.sv - scoreboard bench for spi_tx_feeder with a reactive cs model
`timescale 1ns/1ps
module tb_spi_tx_feeder;
   localparam int DW       = 8;
   localparam int DEPTH    = 8;
   localparam int GAP      = 4;
   localparam int START_TO = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          full;
   logic [3:0]    count;
   logic          ovf;
   logic          err;
   logic          clr_err;
   logic          newd;
   logic [DW-1:0] din;
   logic          cs;
   logic          busy;
   logic          sent;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int sent_cnt = 0;
   int last_rise_cyc = -1000;
   int fall_dly = 3;
   int low_len = 20;
   bit auto_cs = 1'b0;
   bit abort_frame = 1'b0;
   bit resp_active = 1'b0;
   logic [DW-1:0] exp_q[$];

   spi_tx_feeder #(
      .DW       (DW),
      .DEPTH    (DEPTH),
      .GAP      (GAP),
      .START_TO (START_TO)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .full    (full),
      .count   (count),
      .ovf     (ovf),
      .err     (err),
      .clr_err (clr_err),
      .newd    (newd),
      .din     (din),
      .cs      (cs),
      .busy    (busy),
      .sent    (sent)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (sent === 1'b1) sent_cnt++;

   // Master model: answers newd with a cs fall, holds cs low, then releases it.
   initial begin : cs_model
      logic [DW-1:0] exp_b;
      cs = 1'b1;
      forever begin
         @(negedge clk);
         if (auto_cs && newd === 1'b1) begin
            resp_active = 1'b1;
            tests++;
            if (cyc - last_rise_cyc < GAP)
               $display("FAIL frame_gap: got %0d cs-high cycles want >= %0d", cyc - last_rise_cyc, GAP);
            if (cyc - last_rise_cyc < GAP) fails++;
            repeat (fall_dly - 1) @(negedge clk);
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL frame_unexpected: got din %02h want no frame", din);
            end else begin
               exp_b = exp_q.pop_front();
               if (din !== exp_b || newd !== 1'b1) begin
                  fails++;
                  $display("FAIL frame_din: got din %02h newd %0b want din %02h newd 1", din, newd, exp_b);
               end
            end
            cs = 1'b0;
            repeat (low_len) @(negedge clk);
            cs = 1'b1;
            last_rise_cyc = cyc;
            @(negedge clk);
            if (!abort_frame) begin
               tests++;
               if (sent !== 1'b1) begin
                  fails++;
                  $display("FAIL frame_sent: got %0b want 1", sent);
               end
            end
            abort_frame = 1'b0;
            resp_active = 1'b0;
         end
      end
   end

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0 || resp_active || count !== 4'd0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n >= budget) begin
         fails++;
         $display("FAIL drain: got %0d bytes pending count %0d want 0 within %0d cycles", exp_q.size(), count, budget);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_en = 1'b0; wr_data = '0; clr_err = 1'b0;
      repeat (3) @(negedge clk);
      tests += 8;
      if (newd !== 1'b0)  begin fails++; $display("FAIL reset_newd: got %0b want 0", newd); end
      if (din !== 8'h00)  begin fails++; $display("FAIL reset_din: got %02h want 00", din); end
      if (full !== 1'b0)  begin fails++; $display("FAIL reset_full: got %0b want 0", full); end
      if (count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
      if (ovf !== 1'b0)   begin fails++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
      if (err !== 1'b0)   begin fails++; $display("FAIL reset_err: got %0b want 0", err); end
      if (busy !== 1'b0)  begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
      if (sent !== 1'b0)  begin fails++; $display("FAIL reset_sent: got %0b want 0", sent); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      int s0 = sent_cnt;
      int n;
      auto_cs = 1'b1; fall_dly = 3; low_len = 20;
      wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
      @(negedge clk);
      wr_en = 1'b0;
      tests++;
      if (count !== 4'd1 || newd !== 1'b0) begin
         fails++; $display("FAIL single_cycle1: got count %0d newd %0b want 1 0", count, newd);
      end
      @(negedge clk);
      tests++;
      if (newd !== 1'b1 || din !== 8'hA5 || busy !== 1'b1) begin
         fails++; $display("FAIL single_cycle2: got newd %0b din %02h busy %0b want 1 a5 1", newd, din, busy);
      end
      n = 0;
      while (sent_cnt == s0 && n < 100) begin @(negedge clk); n++; end
      tests++;
      if (sent_cnt != s0 + 1) begin
         fails++; $display("FAIL single_sent: got %0d pulses want 1", sent_cnt - s0);
      end
      n = 0;
      while (busy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
      tests++;
      if (cyc - last_rise_cyc != GAP + 1) begin
         fails++; $display("FAIL single_busy_drop: got %0d cycles after rise want %0d", cyc - last_rise_cyc, GAP + 1);
      end
      drain(100);
   endtask

   task automatic fill(input logic [DW-1:0] base, input int num);
      auto_cs = 1'b0; cs = 1'b0;
      for (int i = 0; i < num; i++) begin
         wr_en = 1'b1; wr_data = base + DW'(i);
         if (i < DEPTH) exp_q.push_back(wr_data);
         @(negedge clk);
      end
      wr_en = 1'b0;
   endtask

   task automatic test_burst();
      fill(8'h01, 8);
      tests++;
      if (full !== 1'b1 || count !== 4'd8) begin
         fails++; $display("FAIL burst_full: got full %0b count %0d want 1 8", full, count);
      end
      fall_dly = 2; low_len = 4;
      auto_cs = 1'b1; cs = 1'b1;
      drain(2000);
   endtask

   task automatic test_overflow();
      fill(8'h20, 8);
      wr_en = 1'b1; wr_data = 8'hFF;
      @(negedge clk);
      wr_en = 1'b0;
      tests++;
      if (ovf !== 1'b1 || count !== 4'd8) begin
         fails++; $display("FAIL ovf_set: got ovf %0b count %0d want 1 8", ovf, count);
      end
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      tests++;
      if (ovf !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %0b want 0", ovf); end
      auto_cs = 1'b1; cs = 1'b1;
      drain(2000);
   endtask

   task automatic test_push_pop_full();
      fill(8'h10, 8);
      auto_cs = 1'b1; cs = 1'b1;
      wr_en = 1'b1; wr_data = 8'h99; exp_q.push_back(8'h99);
      @(negedge clk);
      wr_en = 1'b0;
      tests++;
      if (ovf !== 1'b0 || count !== 4'd8 || full !== 1'b1) begin
         fails++; $display("FAIL pushpop_full: got ovf %0b count %0d full %0b want 0 8 1", ovf, count, full);
      end
      drain(2000);
   endtask

   task automatic test_timeout();
      int s0 = sent_cnt;
      int hi = 0;
      int lo = 0;
      int n = 0;
      logic [DW-1:0] exp_b;
      auto_cs = 1'b0; cs = 1'b1;
      wr_en = 1'b1; wr_data = 8'h3C; exp_q.push_back(8'h3C);
      @(negedge clk);
      wr_data = 8'h4D; exp_q.push_back(8'h4D);
      @(negedge clk);
      wr_en = 1'b0;
      while (newd !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      exp_b = exp_q.pop_front();
      tests++;
      if (din !== exp_b) begin fails++; $display("FAIL timeout_din: got %02h want %02h", din, exp_b); end
      while (newd === 1'b1 && hi < START_TO + 20) begin hi++; @(negedge clk); end
      tests++;
      if (hi != START_TO) begin fails++; $display("FAIL timeout_hold: got %0d cycles want %0d", hi, START_TO); end
      tests++;
      if (err !== 1'b1) begin fails++; $display("FAIL timeout_err: got %0b want 1", err); end
      tests++;
      if (sent_cnt != s0) begin fails++; $display("FAIL timeout_nosent: got %0d pulses want 0", sent_cnt - s0); end
      fall_dly = 2; low_len = 5;
      auto_cs = 1'b1;
      while (newd !== 1'b1 && lo < 50) begin lo++; @(negedge clk); end
      tests++;
      if (lo != GAP + 1) begin fails++; $display("FAIL timeout_relaunch: got %0d idle cycles want %0d", lo, GAP + 1); end
      drain(500);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      tests++;
      if (err !== 1'b0) begin fails++; $display("FAIL err_clear: got %0b want 0", err); end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      int s0;
      bit seen = 1'b0;
      auto_cs = 1'b1; fall_dly = 2; low_len = 30;
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_data = 8'h61 + DW'(i); exp_q.push_back(wr_data);
         @(negedge clk);
      end
      wr_en = 1'b0;
      while (cs !== 1'b0 && n < 50) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      abort_frame = 1'b1;
      #2 rst = 1'b1;
      #1;
      tests++;
      if (newd !== 1'b0 || count !== 4'd0 || busy !== 1'b0 || sent !== 1'b0) begin
         fails++; $display("FAIL reset_mid: got newd %0b count %0d busy %0b sent %0b want 0 0 0 0", newd, count, busy, sent);
      end
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (newd === 1'b1) seen = 1'b1;
      end
      tests++;
      if (seen) begin fails++; $display("FAIL reset_no_newd: got newd 1 want 0"); end
      s0 = sent_cnt;
      wr_en = 1'b1; wr_data = 8'h5A; exp_q.push_back(8'h5A);
      @(negedge clk);
      wr_en = 1'b0;
      drain(500);
      tests++;
      if (sent_cnt != s0 + 1) begin fails++; $display("FAIL reset_resume: got %0d pulses want 1", sent_cnt - s0); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_push_pop_full();
      test_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no completion by %0t want finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
